// File: rtl/myfifo_burst_reader.sv
// Read-side burst scheduler for the 64-bit dual-clock myfifo, rdclk domain.
// Define MYFIFO_RD_TIMEOUT_EN to flush a residue below BURST_LEN after TIMEOUT cycles.
module myfifo_burst_reader #(
    parameter int BURST_LEN = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic        rdclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [63:0] fifo_q,
    input  logic [9:0]  fifo_rdusedw,
    input  logic        fifo_rdempty,
    output logic        fifo_rdreq,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic        busy,
    output logic [15:0] burst_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [10:0] BURST_LEN_L = 11'(BURST_LEN);

    state_t      state_q;
    logic [10:0] lvl_s;
    logic [10:0] len_q;
    logic [10:0] rem_q;
    logic [15:0] burst_cnt_q;

    logic        rdreq_s;
    logic        pop_s;
    logic        can_issue_s;
    logic        req_sop_s;
    logic        req_eop_s;
    logic        eop_acc_s;
    logic        tmo_fire_s;

    logic        pend_q;
    logic        pend_sop_q;
    logic        pend_eop_q;
    logic [63:0] buf_data_q [2];
    logic [1:0]  buf_sop_q;
    logic [1:0]  buf_eop_q;
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;

    // A full FIFO wraps rdusedw to 0 while rdempty stays low.
    always_comb begin
        if ((fifo_rdusedw == 10'd0) && !fifo_rdempty) begin
            lvl_s = 11'd1024;
        end else begin
            lvl_s = {1'b0, fifo_rdusedw};
        end
    end

    // Read issue, credit and marker decode.
    always_comb begin
        pop_s       = (cnt_q != 2'd0) && out_ready;
        // A pop this cycle frees a slot for the word returned two cycles from now.
        can_issue_s = ({1'b0, cnt_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop_s});
        rdreq_s     = (state_q == ST_BURST) && !fifo_rdempty && can_issue_s;
        req_sop_s   = (rem_q == len_q);
        req_eop_s   = (rem_q == 11'd1);
        eop_acc_s   = pop_s && buf_eop_q[rd_ptr_q];
        cnt_d       = cnt_q + {1'b0, pend_q} - {1'b0, pop_s};
    end

`ifdef MYFIFO_RD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

    logic [15:0] tmo_q;
    logic        lvl_partial_s;

    assign lvl_partial_s = (lvl_s != 11'd0) && (lvl_s < BURST_LEN_L);
    assign tmo_fire_s    = lvl_partial_s && (tmo_q >= TIMEOUT_L);

    // Residue age counter, only while armed with a partial level.
    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            tmo_q <= 16'd0;
        end else if ((state_q == ST_ARM) && enable && lvl_partial_s && !tmo_fire_s) begin
            tmo_q <= tmo_q + 16'd1;
        end else begin
            tmo_q <= 16'd0;
        end
    end
`else
    assign tmo_fire_s = 1'b0;
`endif

    // Burst scheduler state machine and completed-burst counter.
    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= 11'd0;
            rem_q       <= 11'd0;
            burst_cnt_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (lvl_s >= BURST_LEN_L) begin
                        len_q   <= BURST_LEN_L;
                        rem_q   <= BURST_LEN_L;
                        state_q <= ST_BURST;
                    end else if (tmo_fire_s) begin
                        len_q   <= lvl_s;
                        rem_q   <= lvl_s;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (rdreq_s) begin
                        rem_q <= rem_q - 11'd1;
                        if (rem_q == 11'd1) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (eop_acc_s) begin
                        burst_cnt_q <= burst_cnt_q + 16'd1;
                        state_q     <= enable ? ST_ARM : ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-entry output buffer fed by the word returned one cycle after rdreq.
    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            pend_q        <= 1'b0;
            pend_sop_q    <= 1'b0;
            pend_eop_q    <= 1'b0;
            buf_data_q[0] <= 64'd0;
            buf_data_q[1] <= 64'd0;
            buf_sop_q     <= 2'b00;
            buf_eop_q     <= 2'b00;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
        end else begin
            pend_q     <= rdreq_s;
            pend_sop_q <= rdreq_s && req_sop_s;
            pend_eop_q <= rdreq_s && req_eop_s;
            if (pend_q) begin
                buf_data_q[wr_ptr_q] <= fifo_q;
                buf_sop_q[wr_ptr_q]  <= pend_sop_q;
                buf_eop_q[wr_ptr_q]  <= pend_eop_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign fifo_rdreq = rdreq_s;
    assign out_valid  = (cnt_q != 2'd0);
    assign out_data   = buf_data_q[rd_ptr_q];
    assign out_sop    = out_valid && buf_sop_q[rd_ptr_q];
    assign out_eop    = out_valid && buf_eop_q[rd_ptr_q];
    assign busy       = (state_q == ST_BURST) || (state_q == ST_DONE);
    assign burst_cnt  = burst_cnt_q;

endmodule

// File: tb/tb_myfifo_burst_reader.sv
// Directed bench for myfifo_burst_reader with a behavioural myfifo read-side model.
module tb_myfifo_burst_reader;

    localparam int BL  = 32;
    localparam int TMO = 100;

    logic        rdclk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [63:0] fifo_q = 64'd0;
    logic [9:0]  fifo_rdusedw;
    logic        fifo_rdempty;
    logic        fifo_rdreq;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic        busy;
    logic [15:0] burst_cnt;

    always #5 rdclk = ~rdclk;

    myfifo_burst_reader #(.BURST_LEN(BL), .TIMEOUT(TMO)) dut (
        .rdclk(rdclk), .rst_n(rst_n), .enable(enable), .fifo_q(fifo_q),
        .fifo_rdusedw(fifo_rdusedw), .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .burst_cnt(burst_cnt)
    );

    // FIFO model
    logic [63:0] mem [0:1023];
    int          wr_idx = 0;
    int          rd_idx = 0;
    logic        ovr_en = 1'b0;
    logic [9:0]  ovr_usedw = 10'd0;
    logic        ovr_empty = 1'b1;

    assign fifo_rdusedw = ovr_en ? ovr_usedw : 10'(wr_idx - rd_idx);
    assign fifo_rdempty = ovr_en ? ovr_empty : (wr_idx == rd_idx);

    always @(posedge rdclk) begin
        if (fifo_rdreq) begin
            if (rd_idx < wr_idx) begin
                fifo_q <= mem[rd_idx];
                rd_idx <= rd_idx + 1;
            end else begin
                fifo_q <= 64'd0;
            end
        end
    end

    // Ready generation: forced level or toggling every cycle
    logic rdy_force = 1'b1;
    logic rdy_val   = 1'b1;
    logic tog_q     = 1'b0;
    always @(posedge rdclk) tog_q <= ~tog_q;
    assign out_ready = rdy_force ? rdy_val : tog_q;

    // Monitor
    int          cyc = 0;
    int          rq_n = 0;
    int          rx_n = 0;
    int          viol_empty = 0;
    int          viol_stable = 0;
    int          rq_cyc [0:4095];
    logic [63:0] rx_data [0:4095];
    logic        rx_sop [0:4095];
    logic        rx_eop [0:4095];
    logic        prev_stall = 1'b0;
    logic [65:0] prev_word = 66'd0;

    always @(posedge rdclk) cyc <= cyc + 1;

    always @(negedge rdclk) begin
        if (fifo_rdreq) begin
            if (rq_n < 4096) rq_cyc[rq_n] = cyc;
            rq_n = rq_n + 1;
            if (fifo_rdempty) viol_empty = viol_empty + 1;
        end
        if (out_valid && out_ready) begin
            if (rx_n < 4096) begin
                rx_data[rx_n] = out_data;
                rx_sop[rx_n]  = out_sop;
                rx_eop[rx_n]  = out_eop;
            end
            rx_n = rx_n + 1;
        end
        if (prev_stall && (!out_valid || ({out_data, out_sop, out_eop} != prev_word)))
            viol_stable = viol_stable + 1;
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_data, out_sop, out_eop};
    end

    int total = 0;
    int bad   = 0;

    function automatic logic [63:0] word_of(input int i);
        return {32'hCAFE_0000, 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rdclk);
        #1;
    endtask

    task automatic preload(input int n);
        for (int k = 0; k < n; k++) begin
            mem[wr_idx] = word_of(wr_idx);
            wr_idx = wr_idx + 1;
        end
    endtask

    task automatic wait_busy(input string tag, input int maxc);
        int k = 0;
        while (!busy && k < maxc) begin
            @(negedge rdclk);
            k++;
        end
        chk(tag, 64'(busy), 64'd1);
    endtask

    task automatic wait_cnt(input string tag, input int target, input int maxc);
        int k = 0;
        while (burst_cnt !== 16'(target) && k < maxc) begin
            @(negedge rdclk);
            k++;
        end
        chk(tag, 64'(burst_cnt), 64'(target));
    endtask

    task automatic wait_rx(input string tag, input int n, input int maxc);
        int k = 0;
        while (rx_n < n && k < maxc) begin
            @(negedge rdclk);
            k++;
        end
        chk(tag, 64'(rx_n >= n), 64'd1);
    endtask

    task automatic wait_rq(input string tag, input int n, input int maxc);
        int k = 0;
        while (rq_n < n && k < maxc) begin
            @(negedge rdclk);
            k++;
        end
        chk(tag, 64'(rq_n >= n), 64'd1);
    endtask

    task automatic check_burst(input string tag, input int rxb, input int wb, input int len);
        chk({tag, "_count"}, 64'(rx_n - rxb >= len), 64'd1);
        for (int i = 0; i < len; i++) begin
            chk({tag, "_data"}, rx_data[rxb + i], word_of(wb + i));
            chk({tag, "_sop"}, 64'(rx_sop[rxb + i]), 64'(i == 0));
            chk({tag, "_eop"}, 64'(rx_eop[rxb + i]), 64'(i == len - 1));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rdreq"}, 64'(fifo_rdreq), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_sop"}, 64'(out_sop), 64'd0);
        chk({tag, "_eop"}, 64'(out_eop), 64'd0);
        chk({tag, "_data"}, out_data, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cnt"}, 64'(burst_cnt), 64'd0);
    endtask

    int rxb;
    int qb;
    int wb;
    int p;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        @(negedge rdclk);
        check_zero_outputs("reset");
        tick();
        rst_n = 1'b1;

        // Threshold burst: 40 words, 32 read back-to-back, 8 remain
        tick();
        rxb = rx_n; qb = rq_n; wb = rd_idx;
        preload(40);
        enable = 1'b1;
        wait_busy("thr_busy", 10);
        tick();
        enable = 1'b0;
        wait_cnt("thr_cnt", 1, 200);
        check_burst("thr", rxb, wb, BL);
        chk("thr_rdreqs", 64'(rq_n - qb), 64'd32);
        chk("thr_consecutive", 64'(rq_cyc[qb + 31] - rq_cyc[qb]), 64'd31);
        chk("thr_remain", 64'(wr_idx - rd_idx), 64'd8);
        repeat (2) tick();
        @(negedge rdclk);
        chk("thr_idle", 64'(busy), 64'd0);

        // Backpressure: ready toggles every cycle
        tick();
        rxb = rx_n; wb = rd_idx;
        preload(24);
        rdy_force = 1'b0;
        enable = 1'b1;
        wait_busy("bp_busy", 10);
        tick();
        enable = 1'b0;
        wait_cnt("bp_cnt", 2, 400);
        check_burst("bp", rxb, wb, BL);
        chk("bp_stable", 64'(viol_stable), 64'd0);
        tick();
        rdy_force = 1'b1;

        // Underrun: FIFO reports empty for 5 cycles after the 10th word
        tick();
        rxb = rx_n; wb = rd_idx;
        preload(32);
        enable = 1'b1;
        wait_busy("ur_busy", 10);
        tick();
        enable = 1'b0;
        wait_rx("ur_10", rxb + 10, 100);
        tick();
        ovr_usedw = 10'd0; ovr_empty = 1'b1; ovr_en = 1'b1;
        qb = rq_n;
        repeat (5) tick();
        chk("ur_no_rdreq", 64'(rq_n - qb), 64'd0);
        ovr_en = 1'b0;
        wait_cnt("ur_cnt", 3, 300);
        check_burst("ur", rxb, wb, BL);
        chk("ur_rdreq_empty", 64'(viol_empty), 64'd0);

        // Partial residue of 5 words
        tick();
        enable = 1'b1;
        repeat (4) tick();
        rxb = rx_n; qb = rq_n; wb = rd_idx;
        preload(5);
        p = cyc;
`ifdef MYFIFO_RD_TIMEOUT_EN
        wait_rq("tmo_start", qb + 1, 200);
        chk("tmo_latency", 64'(rq_cyc[qb] - p), 64'd101);
        tick();
        enable = 1'b0;
        wait_cnt("tmo_cnt", 4, 100);
        check_burst("tmo", rxb, wb, 5);
        chk("tmo_rdreqs", 64'(rq_n - qb), 64'd5);
        tick();
        enable = 1'b1;
        repeat (3) tick();
`else
        repeat (10000) tick();
        chk("notmo_no_rdreq", 64'(rq_n - qb), 64'd0);
        chk("notmo_busy", 64'(busy), 64'd0);
        chk("notmo_cnt", 64'(burst_cnt), 64'd3);
`endif

        // Full wrap: usedw=0/empty=1 idles, usedw=0/empty=0 means 1024 words
        tick();
        ovr_usedw = 10'd0; ovr_empty = 1'b1; ovr_en = 1'b1;
        qb = rq_n;
        repeat (50) tick();
        chk("wrap_empty_no_rdreq", 64'(rq_n - qb), 64'd0);
        ovr_empty = 1'b0;
        p = cyc;
        wait_rq("wrap_start", qb + 1, 20);
        chk("wrap_latency", 64'(rq_cyc[qb] - p), 64'd1);
        tick();
        rst_n = 1'b0; enable = 1'b0; ovr_en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset mid-burst after the 10th word, then a fresh burst
        tick();
        rxb = rx_n;
        preload(40);
        enable = 1'b1;
        wait_rx("rst_10", rxb + 10, 100);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge rdclk);
        check_zero_outputs("rst_mid");
        tick();
        preload(32);
        rst_n = 1'b1;
        rxb = rx_n; wb = rd_idx;
        wait_busy("rst_busy", 10);
        tick();
        enable = 1'b0;
        wait_cnt("rst_cnt", 1, 300);
        check_burst("rst_fresh", rxb, wb, BL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
